// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: reassembles LSB-first words, checks optional
// parity and stop bits, and reports each frame with a one-cycle done strobe.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | line idle, waiting for a falling edge on the synced line
//  ST_START | counting to mid start bit, rejecting glitches
//  ST_DATA  | sampling N_DATA data bits at mid-bit
//  ST_PARITY| sampling and checking the parity bit
//  ST_STOP  | sampling M_STOP stop bits, then publishing the word
module uart_rx #(
    parameter int NB_DATA         = 8,
    parameter int N_DATA          = 8,
    parameter int LOG2_N_DATA     = 4,
    parameter int PARITY_CHECK    = 1,
    parameter int EVEN_ODD_PARITY = 1,
    parameter int M_STOP          = 1,
    parameter int LOG2_M_STOP     = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_data,
    input  logic               i_tick,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_parity_err,
    output logic               o_frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [LOG2_N_DATA-1:0] LAST_DATA = LOG2_N_DATA'(N_DATA - 1);
    localparam logic [LOG2_M_STOP-1:0] LAST_STOP = LOG2_M_STOP'(M_STOP - 1);

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic [3:0]             s_cnt_q, s_cnt_d;
    logic [LOG2_N_DATA-1:0] n_cnt_q, n_cnt_d;
    logic [LOG2_M_STOP-1:0] m_cnt_q, m_cnt_d;
    logic [N_DATA-1:0]      sr_q, sr_d;
    logic                   par_acc_q, par_acc_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   frm_err_now;
    logic [NB_DATA-1:0]     data_ext;
    logic [NB_DATA-1:0]     data_q, data_d;
    logic                   done_q, done_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    // Line is asynchronous; the previous value is taken per tick so edge
    // detection and bit sampling share the same time base.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], i_data};
            if (i_tick) begin
                rx_prev_q <= rx_s;
            end
        end
    end

    always_comb begin
        data_ext               = '0;
        data_ext[N_DATA-1:0]   = sr_q;
    end

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = i_tick ? s_cnt_q + 4'd1 : s_cnt_q;
        n_cnt_d     = n_cnt_q;
        m_cnt_d     = m_cnt_q;
        sr_d        = sr_q;
        par_acc_d   = par_acc_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        frm_err_now = frm_err_q | ~rx_s;
        data_d      = data_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        case (state_q)
            ST_IDLE: begin
                s_cnt_d = 4'd0;
                if (i_tick && rx_prev_q && !rx_s) begin
                    state_d   = ST_START;
                    n_cnt_d   = '0;
                    m_cnt_d   = '0;
                    par_acc_d = 1'b0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (i_tick && s_cnt_q == 4'd7) begin
                    s_cnt_d = 4'd0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_tick && s_cnt_q == 4'd15) begin
                    sr_d      = {rx_s, sr_q[N_DATA-1:1]};
                    par_acc_d = par_acc_q ^ rx_s;
                    n_cnt_d   = n_cnt_q + LOG2_N_DATA'(1);
                    if (n_cnt_q == LAST_DATA) begin
                        s_cnt_d = 4'd0;
                        state_d = (PARITY_CHECK != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (i_tick && s_cnt_q == 4'd15) begin
                    if (EVEN_ODD_PARITY != 0) begin
                        par_err_d = par_acc_q ^ rx_s;
                    end else begin
                        par_err_d = ~(par_acc_q ^ rx_s);
                    end
                    s_cnt_d = 4'd0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (i_tick && s_cnt_q == 4'd15) begin
                    frm_err_d = frm_err_now;
                    m_cnt_d   = m_cnt_q + LOG2_M_STOP'(1);
                    if (m_cnt_q == LAST_STOP) begin
                        data_d  = data_ext;
                        perr_d  = par_err_q;
                        ferr_d  = frm_err_now;
                        done_d  = 1'b1;
                        s_cnt_d = 4'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                s_cnt_d = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            s_cnt_q   <= 4'd0;
            n_cnt_q   <= '0;
            m_cnt_q   <= '0;
            sr_q      <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_cnt_q   <= n_cnt_d;
            m_cnt_q   <= m_cnt_d;
            sr_q      <= sr_d;
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            data_q    <= data_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign o_data       = data_q;
    assign o_rx_done    = done_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are built bit by bit, expected words go
// into a scoreboard queue and are compared whenever the receiver strobes done.
module tb_uart_rx;

    logic       clk;
    logic       i_reset;
    logic       i_data;
    logic       i_tick;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_parity_err;
    logic       o_frame_err;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];
    int   done_tick[$];
    int   checks    = 0;
    int   failures  = 0;
    int   tick_cnt  = 0;
    int   done_cnt  = 0;
    logic done_prev = 1'b0;

    uart_rx dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_tick      (i_tick),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every four clocks.
    initial begin
        i_tick = 1'b0;
        forever begin
            @(negedge clk) i_tick = 1'b1;
            @(negedge clk) i_tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    end

    always @(posedge clk) if (i_tick) tick_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare every done strobe against the oldest expectation.
    always @(negedge clk) begin
        if (o_rx_done) begin
            done_cnt++;
            done_tick.push_back(tick_cnt);
            chk("done_one_cycle", {31'd0, done_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("sb_nonempty_at_done", sb_q.size(), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", {24'd0, o_data}, {24'd0, e.d});
                chk("sb_parity_err", {31'd0, o_parity_err}, {31'd0, e.pe});
                chk("sb_frame_err", {31'd0, o_frame_err}, {31'd0, e.fe});
            end
        end
        done_prev = o_rx_done;
    end

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (i_tick) k++;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) i_data = b;
        wait_ticks(16);
    endtask

    task automatic idle(input int n);
        @(negedge clk) i_data = 1'b1;
        wait_ticks(n);
    endtask

    // 8 data bits LSB first, one parity bit, one stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.d  = d;
        e.pe = par ^ (^d);
        e.fe = ~stop;
        sb_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic chk_outputs(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        chk({tag, "_data"}, {24'd0, o_data}, {24'd0, d});
        chk({tag, "_perr"}, {31'd0, o_parity_err}, {31'd0, pe});
        chk({tag, "_ferr"}, {31'd0, o_frame_err}, {31'd0, fe});
    endtask

    initial begin
        logic [7:0] ee;
        ee      = 8'hEE;
        i_reset = 1'b0;
        i_data  = 1'b1;

        // Reset held with a toggling line.
        repeat (40) @(negedge clk) i_data = ~i_data;
        chk_outputs("rst", 8'h00, 1'b0, 1'b0);
        chk("rst_done", {31'd0, o_rx_done}, 32'd0);
        chk("rst_done_cnt", done_cnt, 32'd0);
        @(negedge clk) begin
            i_data  = 1'b1;
            i_reset = 1'b1;
        end
        idle(40);
        chk_outputs("post_rst", 8'h00, 1'b0, 1'b0);
        chk("post_rst_done_cnt", done_cnt, 32'd0);

        // Good frame.
        send_frame(8'hEE, 1'b0, 1'b1);
        idle(8);
        chk("good_done_cnt", done_cnt, 32'd1);
        chk_outputs("good", 8'hEE, 1'b0, 1'b0);

        // Parity error, then recovery.
        send_frame(8'h24, 1'b1, 1'b1);
        idle(8);
        chk("perr_done_cnt", done_cnt, 32'd2);
        chk_outputs("perr", 8'h24, 1'b1, 1'b0);
        send_frame(8'h24, 1'b0, 1'b1);
        idle(8);
        chk("perr_clr_done_cnt", done_cnt, 32'd3);
        chk_outputs("perr_clr", 8'h24, 1'b0, 1'b0);

        // Short glitch must be rejected.
        @(negedge clk) i_data = 1'b0;
        wait_ticks(4);
        idle(48);
        chk("glitch_done_cnt", done_cnt, 32'd3);
        chk_outputs("glitch", 8'h24, 1'b0, 1'b0);

        // Stop bit low.
        send_frame(8'h55, 1'b0, 1'b0);
        idle(32);
        chk("ferr_done_cnt", done_cnt, 32'd4);
        chk_outputs("ferr", 8'h55, 1'b0, 1'b1);

        // Reset after data bit 3 of 0xEE.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(ee[i]);
        @(negedge clk) i_reset = 1'b0;
        #1;
        chk_outputs("mid_rst", 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        i_data  = 1'b1;
        i_reset = 1'b1;
        idle(40);
        chk("mid_rst_done_cnt", done_cnt, 32'd4);
        send_frame(8'h24, 1'b0, 1'b1);
        idle(8);
        chk("after_rst_done_cnt", done_cnt, 32'd5);
        chk_outputs("after_rst", 8'h24, 1'b0, 1'b0);

        // Back-to-back frames with no idle gap.
        send_frame(8'hEE, 1'b0, 1'b1);
        send_frame(8'h24, 1'b0, 1'b1);
        idle(16);
        chk("b2b_done_cnt", done_cnt, 32'd7);
        if (done_tick.size() >= 7) begin
            chk("b2b_spacing", done_tick[6] - done_tick[5], 32'd176);
        end else begin
            chk("b2b_tick_records", done_tick.size(), 32'd7);
        end
        chk_outputs("b2b", 8'h24, 1'b0, 1'b0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
